result_collector: RTL and testbench

Downstream stage for an array of `my_module` instances. Samples their `z` outputs on a strobe, detects per-unit changes against the previous sample, and queues one record per change (unit index, new value) in an internal FIFO. The FIFO drains over a valid/ready interface to a monitor or logger. Multiple simultaneous changes are serialized lowest index first.

---
 rtl/result_collector_pkg.sv | 20 ++
 rtl/rc_sync_fifo.sv | 63 ++++++
 rtl/result_collector.sv | 112 +++++++++++
 tb/tb_result_collector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Record layout shared by the collector and the downstream logger.
// A record is {unit index, sampled value}; the value sits in bit 0.
package result_collector_pkg;

    localparam int NUM_UNITS_DEF = 4;
    localparam int UNIT_W_DEF    = $clog2(NUM_UNITS_DEF);
    localparam int REC_W         = UNIT_W_DEF + 1;
    localparam int REC_VAL_LSB   = 0;
    localparam int REC_UNIT_LSB  = 1;

    typedef struct packed {
        logic [UNIT_W_DEF-1:0] unit;
        logic                  val;
    } rec_t;

    function automatic int rec_width(input int num_units);
        return $clog2(num_units) + 1;
    endfunction

endpackage

// File: rtl/rc_sync_fifo.sv
// First-word fall-through FIFO: a push into an empty FIFO is visible next cycle.
// Accepts a push when full if a pop happens in the same cycle; fill is registered.
module rc_sync_fifo #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic [AW:0]      fill
);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             empty, full, push_fire, pop_fire;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_vld   = !empty;
    assign pop_fire  = pop_vld && pop_rdy;
    assign push_rdy  = !full || pop_fire;
    assign push_fire = push_vld && push_rdy;
    assign pop_dat   = pop_vld ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign fill      = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_fire) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/result_collector.sv
// Samples unit outputs on sample_en and queues one {unit, value} record per change, lowest index first.
// Record reaches the head two cycles after the sample; a full FIFO holds changes pending (sticky overflow).
module result_collector
    import result_collector_pkg::*;
#(
    parameter  int NUM_UNITS = 4,
    parameter  int DEPTH     = 8,
    localparam int UNIT_W    = $clog2(NUM_UNITS),
    localparam int FILL_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_UNITS-1:0] z_in,
    input  logic                 sample_en,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [UNIT_W-1:0]    rec_unit,
    output logic                 rec_val,
    output logic                 overflow,
    output logic                 coalesced,
    output logic [FILL_W-1:0]    fill
);

    localparam int RW = rec_width(NUM_UNITS);

    logic [NUM_UNITS-1:0] prev_q, prev_d;
    logic [NUM_UNITS-1:0] cur_q, cur_d;
    logic [NUM_UNITS-1:0] pend_q, pend_d;
    logic                 overflow_q, overflow_d;
    logic                 coalesced_q, coalesced_d;

    logic [NUM_UNITS-1:0] chg;
    logic [UNIT_W-1:0]    scan_k;
    logic                 push_vld, push_rdy, push_fire;
    logic [RW-1:0]        push_dat, pop_dat;

    assign chg = z_in ^ prev_q;

    always_comb begin
        scan_k = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                scan_k = UNIT_W'(i);
            end
        end
    end

    assign push_vld  = |pend_q;
    assign push_fire = push_vld && push_rdy;

    // The value pushed is whatever was sampled last, so a change-and-back yields one record.
    always_comb begin
        push_dat                           = '0;
        push_dat[REC_VAL_LSB]              = cur_q[scan_k];
        push_dat[REC_UNIT_LSB +: UNIT_W]   = scan_k;
    end

    always_comb begin
        prev_d      = prev_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        overflow_d  = overflow_q | (push_vld && !push_rdy);
        coalesced_d = coalesced_q;
        if (push_fire) begin
            pend_d[scan_k] = 1'b0;
        end
        // Applied after the clear so a fresh change on the pushed unit is kept.
        if (sample_en) begin
            prev_d      = z_in;
            cur_d       = z_in;
            pend_d      = pend_d | chg;
            coalesced_d = coalesced_q | (|(pend_q & chg));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            cur_q       <= '0;
            pend_q      <= '0;
            overflow_q  <= 1'b0;
            coalesced_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            overflow_q  <= overflow_d;
            coalesced_q <= coalesced_d;
        end
    end

    rc_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_rdy (push_rdy),
        .push_dat (push_dat),
        .pop_vld  (rec_valid),
        .pop_rdy  (rec_ready),
        .pop_dat  (pop_dat),
        .fill     (fill)
    );

    assign rec_unit  = pop_dat[REC_UNIT_LSB +: UNIT_W];
    assign rec_val   = pop_dat[REC_VAL_LSB];
    assign overflow  = overflow_q;
    assign coalesced = coalesced_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with NUM_UNITS=4, DEPTH=8.
module tb_result_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] z_in;
    logic       sample_en;
    logic       rec_ready;
    logic       rec_valid;
    logic [1:0] rec_unit;
    logic       rec_val;
    logic       overflow;
    logic       coalesced;
    logic [3:0] fill;

    int total = 0;
    int bad   = 0;
    int exp_u[$];
    int exp_v[$];

    result_collector #(
        .NUM_UNITS (4),
        .DEPTH     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .z_in      (z_in),
        .sample_en (sample_en),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_unit  (rec_unit),
        .rec_val   (rec_val),
        .overflow  (overflow),
        .coalesced (coalesced),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sample(input logic [3:0] z);
        z_in      = z;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sample_en = 1'b0;
        rec_ready = 1'b0;
        z_in      = 4'b0000;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic expect_rec(input int u, input int v);
        exp_u.push_back(u);
        exp_v.push_back(v);
    endtask

    task automatic expect_all(input int v);
        for (int u = 0; u < 4; u++) expect_rec(u, v);
    endtask

    task automatic drain(input string tag);
        int w;
        rec_ready = 1'b1;
        while (exp_u.size() > 0) begin
            w = 0;
            while (!rec_valid && w < 8) begin
                tick();
                w++;
            end
            if (!rec_valid) begin
                chk({tag, "_timeout"}, rec_valid, 1);
                exp_u.delete();
                exp_v.delete();
                break;
            end
            chk({tag, "_unit"}, rec_unit, exp_u.pop_front());
            chk({tag, "_val"},  rec_val,  exp_v.pop_front());
            tick();
        end
        idle(3);
        chk({tag, "_empty"}, rec_valid, 0);
        chk({tag, "_fill0"}, fill, 0);
        rec_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        rec_ready = 1'b0;
        z_in      = 4'b0000;

        // reset state
        do_reset();
        chk("rst_valid", rec_valid, 0);
        chk("rst_unit", rec_unit, 0);
        chk("rst_val", rec_val, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_coal", coalesced, 0);
        chk("rst_fill", fill, 0);

        // single change: unit 2 rises
        rec_ready = 1'b1;
        sample(4'b0000);
        tick();
        chk("t1_nochg", rec_valid, 0);
        sample(4'b0100);
        chk("t1_n1_valid", rec_valid, 0);
        tick();
        chk("t1_n2_valid", rec_valid, 1);
        chk("t1_unit", rec_unit, 2);
        chk("t1_val", rec_val, 1);
        chk("t1_fill", fill, 1);
        tick();
        chk("t1_one_only", rec_valid, 0);
        chk("t1_fill0", fill, 0);

        // multi-change ordering: units 0,1,3 on consecutive cycles
        do_reset();
        rec_ready = 1'b1;
        sample(4'b1011);
        chk("t2_n1_valid", rec_valid, 0);
        tick();
        chk("t2_r0_valid", rec_valid, 1);
        chk("t2_r0_unit", rec_unit, 0);
        chk("t2_r0_val", rec_val, 1);
        tick();
        chk("t2_r1_valid", rec_valid, 1);
        chk("t2_r1_unit", rec_unit, 1);
        chk("t2_r1_val", rec_val, 1);
        tick();
        chk("t2_r2_valid", rec_valid, 1);
        chk("t2_r2_unit", rec_unit, 3);
        chk("t2_r2_val", rec_val, 1);
        tick();
        chk("t2_done", rec_valid, 0);

        // backpressure: 12 changes into an 8-deep FIFO
        do_reset();
        sample(4'b1111);
        idle(4);
        chk("t3_fill4", fill, 4);
        sample(4'b0000);
        idle(4);
        chk("t3_fill8", fill, 8);
        chk("t3_ovf_before", overflow, 0);
        sample(4'b1111);
        tick();
        chk("t3_fill_full", fill, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_coal", coalesced, 0);
        expect_all(1);
        expect_all(0);
        expect_all(1);
        drain("t3");
        chk("t3_ovf_sticky", overflow, 1);

        // coalesce: unit 1 up then down while the FIFO is full
        do_reset();
        sample(4'b1111);
        idle(4);
        sample(4'b0000);
        idle(4);
        chk("t4_fill8", fill, 8);
        sample(4'b0010);
        sample(4'b0000);
        chk("t4_coal", coalesced, 1);
        chk("t4_ovf", overflow, 1);
        expect_all(1);
        expect_all(0);
        expect_rec(1, 0);
        drain("t4");
        chk("t4_coal_sticky", coalesced, 1);

        // stall stability, with a second record queued behind the head
        do_reset();
        sample(4'b0001);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", rec_valid, 1);
            chk("t5_hold_unit", rec_unit, 0);
            chk("t5_hold_val", rec_val, 1);
            if (i == 1) sample(4'b0011);
            else tick();
        end
        chk("t5_fill2", fill, 2);
        rec_ready = 1'b1;
        tick();
        chk("t5_next_valid", rec_valid, 1);
        chk("t5_next_unit", rec_unit, 1);
        chk("t5_next_val", rec_val, 1);
        tick();
        chk("t5_empty", rec_valid, 0);

        // reset mid-run with records queued and changes pending
        do_reset();
        sample(4'b1111);
        idle(4);
        sample(4'b0000);
        tick();
        chk("t6_fill5", fill, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", rec_valid, 0);
        chk("t6_fill", fill, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_coal", coalesced, 0);
        tick();
        chk("t6_no_stale", rec_valid, 0);
        expect_rec(0, 1);
        rec_ready = 1'b1;
        sample(4'b0001);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
